// File: rtl/ha_iter_add_ctrl_pkg.sv
// rtl/ha_iter_add_ctrl_pkg.sv - shared state encoding for the iterative half-adder controller
package ha_iter_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ha_iter_add_ctrl_ha_vec.sv
// rtl/ha_iter_add_ctrl_ha_vec.sv - N-bit vector of independent 1-bit half adders
module ha_vec #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_ha
      assign s[i] = x[i] ^ y[i];
      assign c[i] = x[i] & y[i];
    end
  endgenerate

endmodule

// File: rtl/ha_iter_add_ctrl.sv
// rtl/ha_iter_add_ctrl.sv - full N-bit adder built by recirculating sum/carry through one half-adder array
module ha_iter_add_ctrl
  import ha_iter_add_ctrl_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_cout,
  output logic [CW-1:0] out_iters
);

  state_t        state, state_nx;
  logic [N-1:0]  x, y, s, c;
  logic [CW-1:0] cnt;
  logic          cout_acc;
  logic          carry_clear;

  ha_vec #(.N(N)) u_ha_vec (
    .x (x),
    .y (y),
    .s (s),
    .c (c)
  );

  assign carry_clear = (c == '0);
  assign in_ready    = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)    state_nx = ST_ITER;
      ST_ITER: if (carry_clear) state_nx = ST_DONE;
      ST_DONE: if (out_ready)   state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  // Only one iteration can ever carry out of the MSB, so OR-accumulation yields bit N of the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      cout_acc  <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_iters <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x        <= in_a;
            y        <= in_b;
            cnt      <= '0;
            cout_acc <= 1'b0;
          end
        end
        ST_ITER: begin
          cnt      <= cnt + CW'(1);
          cout_acc <= cout_acc | c[N-1];
          if (carry_clear) begin
            out_sum   <= s;
            out_cout  <= cout_acc | c[N-1];
            out_iters <= cnt + CW'(1);
            out_valid <= 1'b1;
          end else begin
            x <= s;
            y <= {c[N-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_iter_add_ctrl.sv
// tb/tb_ha_iter_add_ctrl.sv - directed and randomized checks of ha_iter_add_ctrl at N=4 and N=8
module tb_ha_iter_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;

    int n_chk  = 0;
    int n_fail = 0;

    wire       ir4, ov4, oc4, ir8, ov8, oc8;
    wire [3:0] s4;
    wire [2:0] it4;
    wire [7:0] s8;
    wire [3:0] it8;

    wire       iv4 = in_valid & ~sel;
    wire       iv8 = in_valid & sel;
    wire       or4 = out_ready & ~sel;
    wire       or8 = out_ready & sel;

    wire       ir_m = sel ? ir8 : ir4;
    wire       ov_m = sel ? ov8 : ov4;
    wire       oc_m = sel ? oc8 : oc4;
    wire [7:0] os_m = sel ? s8 : {4'b0, s4};
    wire [3:0] oi_m = sel ? it8 : {1'b0, it4};

    ha_iter_add_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .out_valid(ov4), .out_ready(or4),
        .out_sum(s4), .out_cout(oc4), .out_iters(it4)
    );

    ha_iter_add_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .in_a(in_a), .in_b(in_b), .out_valid(ov8), .out_ready(or8),
        .out_sum(s8), .out_cout(oc8), .out_iters(it8)
    );

    always #5 clk = ~clk;

    task automatic fail(input string tag, input int obs, input int exp);
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int ref_iters(input int a, input int b, input int n);
        int x, y, c, it, mask;
        mask = (1 << n) - 1;
        x = a; y = b; it = 0;
        do begin
            c  = x & y;
            x  = x ^ y;
            y  = (c << 1) & mask;
            it = it + 1;
        end while (c != 0);
        return it;
    endfunction

    task automatic run_op(input int a, input int b, input int hold, input bit toggle);
        int n, mask, tot, e_it, cyc;
        logic [7:0] e_sum;
        logic       e_cout;
        n      = sel ? 8 : 4;
        mask   = (1 << n) - 1;
        a      = a & mask;
        b      = b & mask;
        tot    = a + b;
        e_sum  = 8'(tot & mask);
        e_cout = tot[n];
        e_it   = ref_iters(a, b, n);
        n_chk++;
        if (ir_m !== 1'b1) fail("in_ready_idle", ir_m, 1);
        in_a = 8'(a); in_b = 8'(b); in_valid = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (ir_m !== 1'b0) fail("in_ready_busy", ir_m, 0);
        cyc = 0;
        while (!ov_m && cyc < 2 * n + 4) begin
            in_valid  = 1'($urandom);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (!toggle) in_valid = 1'b0;
        n_chk++;
        if (cyc !== e_it) fail("latency", cyc, e_it);
        n_chk++;
        if (ov_m !== 1'b1) fail("out_valid", ov_m, 1);
        n_chk++;
        if (os_m !== e_sum) fail("out_sum", os_m, e_sum);
        n_chk++;
        if (oc_m !== e_cout) fail("out_cout", oc_m, e_cout);
        n_chk++;
        if (oi_m !== 4'(e_it)) fail("out_iters", oi_m, e_it);
        n_chk++;
        if (!(oi_m >= 1 && oi_m <= n + 1)) fail("iters_range", oi_m, n + 1);
        repeat (hold) begin
            if (toggle) begin
                in_valid = 1'($urandom);
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
            @(posedge clk); #1;
            n_chk++;
            if (ov_m !== 1'b1) fail("hold_valid", ov_m, 1);
            n_chk++;
            if (os_m !== e_sum) fail("hold_sum", os_m, e_sum);
            n_chk++;
            if (ir_m !== 1'b0) fail("hold_in_ready", ir_m, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_chk++;
        if (ov_m !== 1'b0) fail("drained_valid", ov_m, 0);
        n_chk++;
        if (ir_m !== 1'b1) fail("drained_in_ready", ir_m, 1);
        n_chk++;
        if (os_m !== e_sum) fail("drained_sum_kept", os_m, e_sum);
    endtask

    initial begin
        #2;
        n_chk++;
        if (ov4 !== 1'b0) fail("rst_valid4", ov4, 0);
        n_chk++;
        if (ov8 !== 1'b0) fail("rst_valid8", ov8, 0);
        n_chk++;
        if (s4 !== 4'h0) fail("rst_sum4", s4, 0);
        n_chk++;
        if (it4 !== 3'd0) fail("rst_iters4", it4, 0);
        n_chk++;
        if (oc8 !== 1'b0) fail("rst_cout8", oc8, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_chk++;
        if (ir4 !== 1'b1) fail("rst_in_ready4", ir4, 1);
        n_chk++;
        if (ir8 !== 1'b1) fail("rst_in_ready8", ir8, 1);

        sel = 1'b0;
        in_a = 8'h0F; in_b = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ov4 !== 1'b0) fail("midrst_valid", ov4, 0);
        n_chk++;
        if (ir4 !== 1'b1) fail("midrst_in_ready", ir4, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_chk++;
        if (ir4 !== 1'b1) fail("postrst_in_ready", ir4, 1);
        n_chk++;
        if (ov4 !== 1'b0) fail("postrst_valid", ov4, 0);
        run_op(4'b0010, 4'b0001, 0, 1'b0);

        run_op(4'b0011, 4'b0101, 0, 1'b0);
        run_op(4'b1111, 4'b0001, 0, 1'b0);
        run_op(4'b1010, 4'b0101, 0, 1'b0);
        run_op(4'b0111, 4'b0001, 10, 1'b1);

        for (int i = 0; i < 1000; i++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), 1'($urandom));

        sel = 1'b1;
        run_op(8'hFF, 8'h01, 0, 1'b0);
        run_op(8'hAA, 8'h55, 0, 1'b0);
        for (int i = 0; i < 1000; i++)
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 2)), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ha_iter_add_ctrl.md
Name: ha_iter_add_ctrl

Overview:
Sequencing controller that turns the N-bit parallel half-adder array into a full N-bit adder with carry-out. Each cycle it feeds the array a working operand pair (x, y) and recirculates x <= sum, y <= carry<<1 until the carry vector is zero. Operands arrive, and results leave, over valid/ready handshakes. It sits between an operand source and a result consumer and is the only user of its array instance.

Parameters:
N, 4, operand/result width in bits (N >= 2)
CW, $clog2(N+2), width of iteration counter; localparam derived from N, not overridable

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands (high only in IDLE)
in_a  input  N  operand A
in_b  input  N  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  N  (A+B) mod 2^N
out_cout  output  1  carry out, (A+B)>>N
out_iters  output  CW  number of array iterations used (1..N+1)

Behaviour:
- Reset (rst_n low, async): state=IDLE; x, y, out_sum, out_iters = 0; out_cout=0; out_valid=0; in_ready=1 once reset is released. Reset mid-operation discards the operation silently.
- States: IDLE, ITER, DONE. Encoding is binary, held in one registered state variable.
- IDLE: in_ready=1. If in_valid, then at the edge: x<=in_a, y<=in_b, cnt<=0, cout_acc<=0, go to ITER. in_a/in_b are ignored outside the accept edge.
- ITER: in_ready=0. Array computes s=x^y and c=x&y combinationally from the registers. Each edge: cnt<=cnt+1; cout_acc<=cout_acc|c[N-1].
  - If c==0: out_sum<=s, out_cout<=cout_acc|c[N-1], out_iters<=cnt+1, out_valid<=1, go to DONE.
  - Else: x<=s, y<={c[N-2:0],1'b0}, stay in ITER.
- Termination is guaranteed within N+1 iterations. cnt never exceeds N+1, and CW holds N+1 without wrap.
- Latency is accept edge to out_valid high = out_iters cycles (min 1, max N+1).
- DONE: out_valid=1 and out_sum/out_cout/out_iters are held stable until out_ready. On the edge with out_ready=1, out_valid<=0 and the state goes to IDLE.
- There is no same-cycle result drain plus new accept: in_ready stays 0 in DONE, so throughput is at most one operation per out_iters+1 cycles.
- out_ready asserted outside DONE is ignored. in_valid held high through ITER/DONE does not re-accept until IDLE.
- Output registers keep their last value after draining. Only out_valid qualifies them.
- Carry-out rule: at most one iteration can have c[N-1]=1. It is bit N of the true sum and is accumulated with OR.
- X/Z on in_a/in_b when in_valid=0 must not propagate into state.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_ITER=2'd1, ST_DONE=2'd2).
- One sub-module, ha_vec: N-bit parameterised half-adder vector. Inputs are x, y [N-1:0]; outputs are s=x^y and c=x&y. It is built as a generate loop of 1-bit half adders.
- The controller instantiates one ha_vec and holds all registers and the FSM.

Test Plan:
- Reset mid-ITER: start 1111+0001, pull rst_n low on iteration 2 -> out_valid=0 and in_ready=1 immediately after reset; a new op 0010+0001 then completes correctly.
- N=4, in_a=0011, in_b=0101 -> out_sum=1000, out_cout=0, out_iters=4, out_valid 4 cycles after accept.
- N=4, in_a=1111, in_b=0001 (worst case) -> out_sum=0000, out_cout=1, out_iters=5.
- N=4, in_a=1010, in_b=0101 (no carries) -> out_sum=1111, out_cout=0, out_iters=1, out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles after 0111+0001 -> out_valid stays 1, out_sum=1000 stable, in_ready=0 throughout, and in_valid toggling has no effect. Drain -> IDLE next cycle.
- Random: 1000 random pairs at N=4 and N=8 with random out_ready -> {out_cout,out_sum}==a+b and 1<=out_iters<=N+1 for every op. Operations are neither lost nor duplicated.
